fir_taps_ram: RTL and testbench

Run-time reloadable, double-buffered FIR coefficient memory for the tulip DSP chain. Replaces the fixed 2x-interpolator tap ROM. A filter engine reads taps by address with 1-cycle latency. A host loads a new coefficient set into the shadow bank without disturbing reads. The new bank becomes active at the start of the next filter pass, so a pass never mixes coefficient sets.

---
 rtl/fir_taps_ram_if.sv | 26 ++
 rtl/fir_taps_ram.sv | 141 ++++++++++++++
 tb/tb_fir_taps_ram.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_taps_ram_if.sv
// Tap-read and coefficient-load signals shared by the filter engine, the host and fir_taps_ram.
interface fir_taps_ram_if #(
  parameter int COEF_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0]        din_address;
  logic                         din_valid;
  logic signed [COEF_WIDTH-1:0] dout;
  logic                         dout_valid;
  logic                         load_start;
  logic signed [COEF_WIDTH-1:0] load_data;
  logic                         load_valid;
  logic                         load_ready;
  logic                         load_done;
  logic                         active_bank;

  modport master (
    output din_address, din_valid, load_start, load_data, load_valid,
    input  dout, dout_valid, load_ready, load_done, active_bank
  );

  modport slave (
    input  din_address, din_valid, load_start, load_data, load_valid,
    output dout, dout_valid, load_ready, load_done, active_bank
  );
endinterface

// File: rtl/fir_taps_ram.sv
// Double-buffered FIR taps: 1-cycle registered reads never stall; host load throttled by load_ready, bank swap on next address-0 read.
// FIR_TAPS_SYM_FOLD_EN: store only the first half of a symmetric set and mirror read addresses onto it.
module fir_taps_ram #(
  parameter int NUM_TAPS   = 32,
  parameter int COEF_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_TAPS)
) (
  input  logic          clk,
  input  logic          rstn,
  fir_taps_ram_if.slave bus
);

`ifdef FIR_TAPS_SYM_FOLD_EN
  localparam int LOAD_COUNT = (NUM_TAPS + 1) / 2;
`else
  localparam int LOAD_COUNT = NUM_TAPS;
`endif
  localparam int LA  = (LOAD_COUNT > 1) ? $clog2(LOAD_COUNT) : 1;
  localparam int AW1 = ADDR_WIDTH + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;

  // Power-up coefficient set of the 2x interpolator; only defined for the 32x16 build.
  function automatic int tap_default(input int i);
    if (NUM_TAPS != 32 || COEF_WIDTH != 16) return 0;
    case (i)
      0:  return 7;      1:  return -89;    2:  return -79;    3:  return 116;
      4:  return 271;    5:  return 0;      6:  return -511;   7:  return -423;
      8:  return 559;    9:  return 1194;   10: return 1;      11: return -2151;
      12: return -1888;  13: return 2959;   14: return 9834;   15: return 13108;
      16: return 9834;   17: return 2959;   18: return -1888;  19: return -2151;
      20: return 1;      21: return 1194;   22: return 559;    23: return -423;
      24: return -511;   25: return 0;      26: return 271;    27: return 116;
      28: return -79;    29: return -89;    30: return 7;
      default: return 0;
    endcase
  endfunction

  logic [COEF_WIDTH-1:0] bank0 [LOAD_COUNT];
  logic [COEF_WIDTH-1:0] bank1 [LOAD_COUNT];
  // Bank 0 entries read the constant table until the host first overwrites them;
  // like the RAM cells, these flags are untouched by reset and power up clear.
  logic [LOAD_COUNT-1:0] bank0_dirty;

  logic [1:0]            state;
  logic [LA-1:0]         wr_count;
  logic                  wr_en;
  logic                  swap;
  logic                  rd_bank;
  logic                  in_range;
  logic [AW1-1:0]        addr_ext;
  logic [LA-1:0]         phys;
  logic [COEF_WIDTH-1:0] rd_word;

  assign addr_ext = {1'b0, bus.din_address};
  assign in_range = addr_ext < AW1'(NUM_TAPS);

`ifdef FIR_TAPS_SYM_FOLD_EN
  logic [AW1-1:0] mirror;
  assign mirror = AW1'(NUM_TAPS - 1) - addr_ext;
  assign phys   = LA'((addr_ext < mirror) ? addr_ext : mirror);
`else
  assign phys   = LA'(addr_ext);
`endif

  assign swap    = (state == PENDING) && bus.din_valid && (bus.din_address == '0);
  // The address-0 read that triggers the swap already sees the new bank.
  assign rd_bank = bus.active_bank ^ swap;
  assign wr_en   = (state == LOAD) && bus.load_valid;

  assign bus.load_ready = (state == LOAD);

  always_comb begin
    rd_word = '0;
    if (rd_bank)
      rd_word = bank1[phys];
    else if (bank0_dirty[phys])
      rd_word = bank0[phys];
    else
      rd_word = COEF_WIDTH'(tap_default(int'(phys)));
  end

  // Writes always land in the bank that is not serving reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (bus.active_bank) begin
        bank0[wr_count]       <= bus.load_data;
        bank0_dirty[wr_count] <= 1'b1;
      end else begin
        bank1[wr_count] <= bus.load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
    end else begin
      bus.dout_valid <= bus.din_valid;
      if (bus.din_valid)
        bus.dout <= in_range ? rd_word : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      wr_count        <= '0;
      bus.active_bank <= 1'b0;
      bus.load_done   <= 1'b0;
    end else begin
      bus.load_done <= swap;
      case (state)
        IDLE: begin
          if (bus.load_start) begin
            state    <= LOAD;
            wr_count <= '0;
          end
        end
        LOAD: begin
          if (bus.load_valid) begin
            wr_count <= wr_count + LA'(1);
            if (wr_count == LA'(LOAD_COUNT - 1))
              state <= PENDING;
          end
        end
        PENDING: begin
          if (swap) begin
            state           <= IDLE;
            bus.active_bank <= ~bus.active_bank;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_taps_ram.sv
// Directed bench for fir_taps_ram: default readback, reload/swap, gapped load, reset mid-load, out-of-range read.
module tb_fir_taps_ram;
  localparam int NT = 32;
  localparam int CW = 16;
  localparam int AW = 5;
`ifdef FIR_TAPS_SYM_FOLD_EN
  localparam int LC = (NT + 1) / 2;
`else
  localparam int LC = NT;
`endif

  logic clk;
  logic rstn;
  int   n_assert;
  int   n_fail;
  int   act [32];

  int def_tbl [32] = '{7, -89, -79, 116, 271, 0, -511, -423, 559, 1194, 1, -2151, -1888, 2959, 9834, 13108,
                       9834, 2959, -1888, -2151, 1, 1194, 559, -423, -511, 0, 271, 116, -79, -89, 7, 0};

  fir_taps_ram_if #(.COEF_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();
  fir_taps_ram_if #(.COEF_WIDTH(CW), .ADDR_WIDTH(5))  bus31 ();

  fir_taps_ram #(.NUM_TAPS(NT), .COEF_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  fir_taps_ram #(.NUM_TAPS(31), .COEF_WIDTH(CW), .ADDR_WIDTH(5)) dut31 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus31)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pmap(input int a);
`ifdef FIR_TAPS_SYM_FOLD_EN
    return (a < NT - 1 - a) ? a : NT - 1 - a;
`else
    return a;
`endif
  endfunction

  task automatic rd(input int a, input string tag);
    bus.din_address = AW'(a);
    bus.din_valid   = 1'b1;
    tick();
    check(tag, bus.dout, act[pmap(a)]);
    check({tag, "_vld"}, bus.dout_valid, 1);
    bus.din_valid = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    bus.din_address   = '0; bus.din_valid   = 1'b0; bus.load_start   = 1'b0;
    bus.load_data     = '0; bus.load_valid  = 1'b0;
    bus31.din_address = '0; bus31.din_valid = 1'b0; bus31.load_start = 1'b0;
    bus31.load_data   = '0; bus31.load_valid = 1'b0;
    for (int p = 0; p < 32; p++) act[p] = def_tbl[p];

    // Reset state
    repeat (3) tick();
    check("rst_dout", bus.dout, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_load_done", bus.load_done, 0);
    check("rst_active_bank", bus.active_bank, 0);
    rstn = 1'b1;
    tick();

    // Default set, back-to-back reads
    for (int a = 0; a < 32; a++) begin
      bus.din_address = AW'(a);
      bus.din_valid   = 1'b1;
      tick();
      check($sformatf("dflt_rd%0d", a), bus.dout, act[pmap(a)]);
      check("dflt_vld", bus.dout_valid, 1);
    end
    bus.din_valid = 1'b0;
    tick();
    check("idle_vld_low", bus.dout_valid, 0);
    check("idle_dout_hold", bus.dout, act[pmap(31)]);

    // Reset after 10 coefficients of a load
    rd(15, "pre_rst_rd15");
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check("ld_rdy_rise", bus.load_ready, 1);
    for (int k = 0; k < 10; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = CW'(900 + k);
      tick();
    end
    bus.load_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("mid_rst_dout", bus.dout, 0);
    check("mid_rst_dout_valid", bus.dout_valid, 0);
    check("mid_rst_load_ready", bus.load_ready, 0);
    check("mid_rst_load_done", bus.load_done, 0);
    check("mid_rst_active_bank", bus.active_bank, 0);
    tick();
    rstn = 1'b1;
    tick();
    rd(0, "post_rst_rd0");
    rd(15, "post_rst_rd15");
    rd(9, "post_rst_rd9");

    // Full load of k*3-40, swap on the next address-0 read
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int k = 0; k < LC; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = CW'(k * 3 - 40);
      tick();
    end
    bus.load_valid = 1'b0;
    check("ld_rdy_fall", bus.load_ready, 0);
    check("pend_active_bank", bus.active_bank, 0);
    rd(5, "pend_rd5");
    check("pend_no_done", bus.load_done, 0);
    for (int k = 0; k < LC; k++) act[k] = k * 3 - 40;
    rd(0, "swap_rd0");
    check("swap_active_bank", bus.active_bank, 1);
    check("swap_load_done", bus.load_done, 1);
    tick();
    check("done_pulse_end", bus.load_done, 0);
    rd(31, "new_rd31");
    rd(17, "new_rd17");
    rd(5, "new_rd5");

    // Gapped load into bank 0 with a stray load_start mid-load
    bus.load_start = 1'b1;
    tick();
    for (int i = 0; i < 2 * LC; i++) begin
      bus.load_valid = (i % 2 == 0);
      bus.load_data  = CW'(100 + i / 2);
      bus.load_start = (i == 5);
      tick();
      if (i == 3) check("gap_rdy_mid", bus.load_ready, 1);
    end
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = CW'(-1);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("gap_rdy_low%0d", j), bus.load_ready, 0);
      tick();
    end
    bus.load_valid = 1'b0;
    check("gap_active_bank", bus.active_bank, 1);
    for (int k = 0; k < LC; k++) act[k] = 100 + k;
    rd(0, "gap_swap_rd0");
    check("gap_swap_active_bank", bus.active_bank, 0);
    check("gap_swap_load_done", bus.load_done, 1);
    for (int a = 0; a < 32; a++) begin
      bus.din_address = AW'(a);
      bus.din_valid   = 1'b1;
      tick();
      check($sformatf("gap_rd%0d", a), bus.dout, act[pmap(a)]);
    end
    bus.din_valid = 1'b0;
    tick();
    rd(31, "gap_rd31");
    rd(16, "gap_rd16");
    rd(15, "gap_rd15");

    // 31-tap instance: address past the last tap
    bus31.din_address = 5'd31;
    bus31.din_valid   = 1'b1;
    tick();
    check("nt31_rd31", bus31.dout, 0);
    check("nt31_rd31_vld", bus31.dout_valid, 1);
    bus31.din_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
